// File: rtl/uart_pkg.sv
// uart_pkg -- shared UART constants, FSM state encoding and helpers (rev 1.0).
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
`default_nettype none

package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int NIBBLE_W             = 4;
    localparam int CLKS_PER_BIT_DEFAULT = 5208;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_rx_state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// uart_rx_sync -- two-flop synchroniser for the idle-high serial line (rev 1.0).
`default_nettype none

module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Reset to 1 so a reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_operand_rx.sv
// uart_operand_rx -- 8N1 UART receiver splitting each byte into adder operands (rev 1.0).
// Define UART_RX_PARITY_EN for 8E1 frames with a live parity_err_o.
`default_nettype none

module uart_operand_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_i,
    output logic [NIBBLE_W-1:0] a_o,
    output logic [NIBBLE_W-1:0] b_o,
    output logic                valid_o,
    output logic                frame_err_o,
    output logic                parity_err_o,
    output logic                busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    uart_rx_state_t       state, state_nxt;
    logic                 rxs;
    logic [CNT_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 half_tick, bit_tick;
    logic                 cnt_clr, bit_clr, shift_en, set_valid, set_ferr;
`ifdef UART_RX_PARITY_EN
    logic                 chk_par, set_perr, mismatch, parity_err;
`endif

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_i),
        .q     (rxs)
    );

    assign half_tick = (baud_cnt == HALF_LAST);
    assign bit_tick  = (baud_cnt == FULL_LAST);
    assign busy_o    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        bit_clr   = 1'b0;
        shift_en  = 1'b0;
        set_valid = 1'b0;
        set_ferr  = 1'b0;
`ifdef UART_RX_PARITY_EN
        chk_par   = 1'b0;
        set_perr  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_nxt = START;
                    cnt_clr   = 1'b1;
                    bit_clr   = 1'b1;
                end
            end
            START: begin
                // Line high again at mid start bit means a glitch, not a frame.
                if (half_tick) begin
                    cnt_clr   = 1'b1;
                    state_nxt = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    cnt_clr   = 1'b1;
                    chk_par   = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    cnt_clr = 1'b1;
                    if (!rxs) begin
                        set_ferr  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end else begin
                        state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (mismatch) set_perr  = 1'b1;
                        else          set_valid = 1'b1;
`else
                        set_valid = 1'b1;
`endif
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            a_o         <= '0;
            b_o         <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            baud_cnt    <= cnt_clr ? '0 : baud_cnt + 1'b1;
            if (bit_clr)       bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
            if (shift_en)      shreg   <= {rxs, shreg[DATA_BITS-1:1]};
            if (set_valid)     {a_o, b_o} <= shreg;
            valid_o     <= set_valid;
            frame_err_o <= set_ferr;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Mismatch is remembered from the parity slot until the stop-bit verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch   <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (bit_clr)      mismatch <= 1'b0;
            else if (chk_par) mismatch <= (rxs != even_parity(shreg));
            parity_err <= set_perr;
        end
    end
    assign parity_err_o = parity_err;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_operand_rx.sv
// tb_uart_operand_rx -- vector table plus scoreboard bench for uart_operand_rx.
`default_nettype none

module tb_uart_operand_rx;

    localparam int N = 8;
    localparam logic [1:0] K_VALID = 2'd0;
    localparam logic [1:0] K_FERR  = 2'd1;
    localparam logic [1:0] K_PERR  = 2'd2;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       par_flip;
        logic [1:0] kind;
        logic [3:0] a;
        logic [3:0] b;
    } vec_t;

    typedef struct {
        logic [1:0] kind;
        logic [3:0] a;
        logic [3:0] b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [3:0] a_o, b_o;
    logic       valid_o, frame_err_o, parity_err_o, busy_o;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    logic lat_armed = 1'b0;
    logic [3:0] last_a, last_b;
    vec_t vecs[$];
    exp_t sb[$];

    uart_operand_rx #(.CLKS_PER_BIT(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (rx),
        .a_o          (a_o),
        .b_o          (b_o),
        .valid_o      (valid_o),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 500000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        logic [1:0] kind;
        int npulse;
        forever begin
            @(negedge clk);
            npulse = int'(valid_o) + int'(frame_err_o) + int'(parity_err_o);
            if (npulse != 0) begin
                check("single_pulse", (npulse == 1), 1);
                kind = valid_o ? K_VALID : (frame_err_o ? K_FERR : K_PERR);
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pulse: got kind %0d expected none (cycle %0d)", kind, cyc);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind", kind, e.kind);
                    check("a_at_pulse", a_o, e.a);
                    check("b_at_pulse", b_o, e.b);
                    if (valid_o && lat_armed) begin
                        check("valid_latency", cyc - start_cyc, 79);
                        lat_armed = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic drive_bit(input logic v);
        @(posedge clk);
        #1 rx = v;
        repeat (N - 1) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pf);
        @(posedge clk);
        #1 rx = 1'b0;
        start_cyc = cyc;
        repeat (N - 1) @(posedge clk);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d ^ pf);
`endif
        drive_bit(stop);
    endtask

    task automatic expect_pulse(input logic [1:0] k, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        e.kind = k;
        e.a    = a;
        e.b    = b;
        sb.push_back(e);
    endtask

    initial begin
        vecs.push_back('{8'hFF, 1'b1, 1'b0, K_VALID, 4'hF, 4'hF});
        vecs.push_back('{8'h00, 1'b1, 1'b0, K_VALID, 4'h0, 4'h0});
        vecs.push_back('{8'hA5, 1'b1, 1'b0, K_VALID, 4'hA, 4'h5});
        vecs.push_back('{8'h5A, 1'b1, 1'b0, K_VALID, 4'h5, 4'hA});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h35, 1'b1, 1'b1, K_PERR,  4'h5, 4'hA});
        vecs.push_back('{8'h81, 1'b1, 1'b0, K_VALID, 4'h8, 4'h1});
`endif

        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", a_o, 0);
        check("reset_b", b_o, 0);
        check("reset_valid", valid_o, 0);
        check("reset_ferr", frame_err_o, 0);
        check("reset_perr", parity_err_o, 0);
        check("reset_busy", busy_o, 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // 0x35 with latency measurement, then table frames back to back
        expect_pulse(K_VALID, 4'h3, 4'h5);
        lat_armed = 1'b1;
        send_frame(8'h35, 1'b1, 1'b0);
        foreach (vecs[i]) begin
            expect_pulse(vecs[i].kind, vecs[i].a, vecs[i].b);
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].par_flip);
            last_a = vecs[i].a;
            last_b = vecs[i].b;
        end
        rx = 1'b1;
        repeat (3 * N) @(posedge clk);
        check("latency_seen", lat_armed, 0);

        // Three-cycle glitch is a false start
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("glitch_busy_high", busy_o, 1);
        repeat (20) @(posedge clk);
        #1;
        check("glitch_busy_low", busy_o, 0);
        check("glitch_a_held", a_o, last_a);
        check("glitch_b_held", b_o, last_b);

        // Bad stop bit followed by a 30-bit break, then a clean frame
        expect_pulse(K_FERR, last_a, last_b);
        send_frame(8'hA6, 1'b0, 1'b0);
        repeat (30 * N) @(posedge clk);
        #1 rx = 1'b1;
        check("break_a_held", a_o, last_a);
        repeat (2 * N) @(posedge clk);
        expect_pulse(K_VALID, 4'h1, 4'h2);
        send_frame(8'h12, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (2 * N) @(posedge clk);

        // Reset during data bit 4 of 0x77, released during its stop bit
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (N - 1) @(posedge clk);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h77 >> i));
        @(posedge clk);
        #1 rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_a", a_o, 0);
        check("midrst_b", b_o, 0);
        check("midrst_valid", valid_o, 0);
        check("midrst_busy", busy_o, 0);
        repeat (4) @(posedge clk);
        for (int i = 5; i < 8; i++) drive_bit(1'(8'h77 >> i));
        @(posedge clk);
        #1 rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4 + 2 * N) @(posedge clk);
        #1;
        check("postrst_a", a_o, 0);
        check("postrst_b", b_o, 0);
        expect_pulse(K_VALID, 4'h4, 4'hC);
        send_frame(8'h4C, 1'b1, 1'b0);
        rx = 1'b1;

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
